seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Multiplexed N-digit hex 7-segment display driver with per-digit decimal points.
//  Time-multiplexes one shared segment bus across DIGITS digit strobes.
//  Double-buffers the displayed value so updates take effect only at frame boundaries (no tearing).
//  Also provides leading-zero suppression, global blanking, anti-ghost dead time and selectable output polarity.
//  Sits between the datapath (value source) and board display pins.
// PARAMETERS
//  DIGITS         4    number of digits, >=1; digit 0 = value[3:0] (least significant)
//  CLK_DIV        1000 clk cycles per digit slot, >=2
//  LZ_SUPPRESS    1    1: blank leading zero digits (digit 0 never blanked)
//  SEG_ACTIVE_LOW 0    1: seg/dp pins inverted (lit = 0)
//  DIG_ACTIVE_LOW 0    1: dig pins inverted (selected = 0)
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  load       in   1          1-cycle strobe: capture value/dp_in into shadow
//  value      in   4*DIGITS   hex nibbles to display
//  dp_in      in   DIGITS     decimal point per digit, 1 = lit
//  blank_in   in   1          1 = all digits off (scan continues)
//  seg        out  7          segments {A,B,C,D,E,F,G}, polarity per SEG_ACTIVE_LOW
//  dp         out  1          decimal point of selected digit, polarity per SEG_ACTIVE_LOW
//  dig        out  DIGITS     one-hot digit select, polarity per DIG_ACTIVE_LOW
//  frame_tick out  1          1-cycle pulse at frame boundary
//  pending    out  1          shadow holds a load not yet displayed
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - presc=0, idx=0, disp/disp_dp=0, shadow=0, pending=0, frame_tick=0.
//   - seg/dp/dig driven to unlit/unselected logic level (polarity applied).
//   - Reset mid-frame aborts the frame and discards any pending load.
//  Scan counters:
//   - presc counts 0..CLK_DIV-1, then wraps to 0.
//   - On wrap, idx increments; idx wraps DIGITS-1 -> 0.
//   - Frame boundary B = (presc==CLK_DIV-1 && idx==DIGITS-1).
//  Load / shadow:
//   - load=1: shadow<=value, shadow_dp<=dp_in, pending<=1 (later load overwrites earlier).
//   - At B: if load -> disp<=value directly; else if pending -> disp<=shadow. Then pending<=0.
//   - load and B in the same cycle: the loaded value is displayed in the next frame; pending ends 0.
//   - frame_tick is registered; it is high in the cycle after B.
//  Outputs (registered):
//   - Outputs at cycle t are a function of idx/presc/disp/blank_in at cycle t-1.
//   - dig: one-hot on bit idx.
//   - dig all unselected when presc==0 (one-cycle dead time per slot), or when blank_in=1.
//   - seg = decode(disp nibble idx), as hex {A..G}:
//     0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47
//   - Leading-zero blank (LZ_SUPPRESS=1): digit i>0 with nibbles i..DIGITS-1 all zero -> seg=0.
//   - dp is still driven from disp_dp[idx] on a leading-zero-blanked digit.
//   - Polarity inversion is applied last, to seg, dp and dig.
// TESTING (DIGITS=4, CLK_DIV=4, active-high unless stated)
//  1. Reset, then load value=16'h12AF, dp_in=0:
//     - frame_tick after first B; pending 1 -> 0 at B.
//     - Next frame: dig 0001/0010/0100/1000, each selected 3 of 4 cycles.
//     - seg per digit 0..3 = 47, 77, 6D, 30.
//  2. Load 16'h0005 -> digit 0 seg=5B; digits 1..3 seg=00, dig still strobed.
//     - Repeat with LZ_SUPPRESS=0 -> digits 1..3 seg=7E.
//  3. Mid-frame tearing and simultaneous events:
//     - Load 16'h1111 mid-frame -> displayed digits unchanged until B; pending=1 until B.
//     - Load asserted exactly at B -> value shown next frame, pending ends 0.
//  4. blank_in=1 for one frame -> dig=0000 throughout, counters keep running.
//     - Release -> scan resumes at the correct idx.
//  5. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value digit 0=8 -> seg=0000000, dig=1110 on digit 0.
//     - During reset -> seg=7F, dp=1, dig=1111.
//  6. Assert rst mid-frame with pending=1 -> next cycle all outputs unlit, pending=0.
//     - After release, scan restarts at idx=0 showing 0 (digit 0 seg=7E).

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus between a value source and the multiplexed 7-segment driver.
// The source uses the master modport and the driver uses the slave modport.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     dig;
  logic                  frame_tick;
  logic                  pending;

  modport master (
    output load, value, dp_in, blank_in,
    input  seg, dp, dig, frame_tick, pending
  );

  modport slave (
    input  load, value, dp_in, blank_in,
    output seg, dp, dig, frame_tick, pending
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit hex 7-segment driver with a frame-synchronous shadow value,
// leading-zero suppression, blanking, one-cycle dead time and configurable pin polarity.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int LZ_SUPPRESS    = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     LAST_PRESC = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_INV     = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_INV    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h7E;
      4'h1: f_decode = 7'h30;
      4'h2: f_decode = 7'h6D;
      4'h3: f_decode = 7'h79;
      4'h4: f_decode = 7'h33;
      4'h5: f_decode = 7'h5B;
      4'h6: f_decode = 7'h5F;
      4'h7: f_decode = 7'h70;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h7B;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h1F;
      4'hC: f_decode = 7'h4E;
      4'hD: f_decode = 7'h3D;
      4'hE: f_decode = 7'h4F;
      default: f_decode = 7'h47;
    endcase
  endfunction

  logic [PW-1:0]              r_presc;
  logic [IW-1:0]              r_idx;
  logic [DIGITS-1:0][3:0]     r_disp;
  logic [DIGITS-1:0]          r_disp_dp;
  logic [DIGITS-1:0][3:0]     r_shadow;
  logic [DIGITS-1:0]          r_shadow_dp;
  logic                       r_pending;
  logic                       r_frame_tick;
  logic [6:0]                 r_seg;
  logic                       r_dp;
  logic [DIGITS-1:0]          r_dig;

  logic [DIGITS-1:0][3:0]     w_value;
  logic                       w_frame_end;
  logic [DIGITS-1:0]          w_lz_blank;
  logic [6:0]                 w_seg_lit;
  logic [DIGITS-1:0]          w_dig_sel;

  assign w_value     = bus.value;
  assign w_frame_end = (r_presc == LAST_PRESC) && (r_idx == LAST_IDX);

  // A digit is blanked when it and every more significant nibble are zero.
  always_comb begin : lz_scan
    logic zero_above;
    // NOTE: every variable gets a default first so no path can infer a latch.
    zero_above = 1'b1;
    w_lz_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above && (r_disp[i] == 4'h0);
      w_lz_blank[i] = zero_above && (LZ_SUPPRESS != 0);
    end
  end

  assign w_seg_lit = w_lz_blank[r_idx] ? 7'h00 : f_decode(r_disp[r_idx]);
  assign w_dig_sel = ((r_presc == '0) || bus.blank_in) ? '0 : (DIGITS'(1) << r_idx);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the display and shadow buffers are reset so the first frame shows a defined 0.
      r_presc      <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_disp_dp    <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg        <= SEG_INV;
      r_dp         <= DP_INV;
      r_dig        <= DIG_INV;
    end else begin
      if (r_presc == LAST_PRESC) begin
        r_presc <= '0;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (bus.load) begin
        r_shadow    <= w_value;
        r_shadow_dp <= bus.dp_in;
      end

      // A load coinciding with the frame end bypasses the shadow and leaves nothing pending.
      if (w_frame_end) begin
        if (bus.load) begin
          r_disp    <= w_value;
          r_disp_dp <= bus.dp_in;
        end else if (r_pending) begin
          r_disp    <= r_shadow;
          r_disp_dp <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (bus.load) begin
        r_pending <= 1'b1;
      end

      r_frame_tick <= w_frame_end;
      r_seg        <= w_seg_lit ^ SEG_INV;
      r_dp         <= r_disp_dp[r_idx] ^ DP_INV;
      r_dig        <= w_dig_sel ^ DIG_INV;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.dig        = r_dig;
  assign bus.frame_tick = r_frame_tick;
  assign bus.pending    = r_pending;

endmodule
